// File: rtl/timer_reload_ctrl.sv
// ============================================================================
// timer_reload_ctrl
//
// Purpose
//   Reload controller for a bank of TIMER_NUM timers. Each expiry pulse on
//   time_out[i] marks channel i as pending. One pending channel per cycle is
//   granted round-robin. The granted channel's load_value slice is loaded
//   from its period register, and its pending bit clears. A second expiry on
//   a channel that is still waiting is merged into the first, and the
//   channel's sticky overflow flag is raised to record the lost event.
//
// Parameters
//   TIMER_NUM       number of timer channels
//   LOAD_W          width of one channel's load / period value
//   DEFAULT_PERIOD  reset value of every period register
//
// Ports
//   clk         in   1                   clock, rising edge
//   rst_n       in   1                   asynchronous active-low reset
//   time_out    in   TIMER_NUM           per-channel expiry pulses
//   load_value  out  TIMER_NUM*LOAD_W    reload values, channel i at [i*LOAD_W +: LOAD_W]
//   cfg_we      in   1                   period register write strobe
//   cfg_idx     in   $clog2(TIMER_NUM)   channel index for the write (out of range: ignored)
//   cfg_wdata   in   LOAD_W              period value to write
//   busy        out  1                   any channel has a reload pending (registered)
//   overflow    out  TIMER_NUM           sticky lost-event flags
//   ovf_clr     in   1                   clears all overflow flags
//
// Optional feature (macro TIMEOUT_CNT_EN)
//   cnt_idx     in   $clog2(TIMER_NUM)   channel whose event count is read
//   cnt_rdata   out  8                   saturating count of sampled time_out events
// ============================================================================
module timer_reload_ctrl #(
    parameter int TIMER_NUM      = 5,
    parameter int LOAD_W         = 10,
    parameter int DEFAULT_PERIOD = 9,
    // Width of a channel index; kept at least 1 so a single-channel build is legal.
    localparam int IDX_W = (TIMER_NUM > 1) ? $clog2(TIMER_NUM) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [TIMER_NUM-1:0]        time_out,
    output logic [TIMER_NUM*LOAD_W-1:0] load_value,
    input  logic                        cfg_we,
    input  logic [IDX_W-1:0]            cfg_idx,
    input  logic [LOAD_W-1:0]           cfg_wdata,
    output logic                        busy,
    output logic [TIMER_NUM-1:0]        overflow,
    input  logic                        ovf_clr
`ifdef TIMEOUT_CNT_EN
   ,input  logic [IDX_W-1:0]            cnt_idx,
    output logic [7:0]                  cnt_rdata
`endif
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [LOAD_W-1:0]    r_period [TIMER_NUM];
    logic [LOAD_W-1:0]    r_load   [TIMER_NUM];
    logic [TIMER_NUM-1:0] r_pending;
    logic [TIMER_NUM-1:0] r_overflow;
    logic [IDX_W-1:0]     r_ptr;      // last granted channel

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                 w_cfg_vld;
    logic                 w_gnt_vld;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic [TIMER_NUM-1:0] w_gnt_oh;
    logic                 w_wr_hit;
    logic [LOAD_W-1:0]    w_reload_val;
    logic [TIMER_NUM-1:0] w_pend_nxt;
    logic [TIMER_NUM-1:0] w_ovf_set;
    logic [TIMER_NUM-1:0] w_ovf_nxt;

    // (base + off) modulo TIMER_NUM, for base < TIMER_NUM and 1 <= off <= TIMER_NUM.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int               off);
        int sum;
        sum = int'(base) + off;
        if (sum >= TIMER_NUM) begin
            sum = sum - TIMER_NUM;
        end
        return IDX_W'(sum);
    endfunction

    // Writes to channel indices that do not exist are dropped.
    assign w_cfg_vld = cfg_we && ({1'b0, cfg_idx} < (IDX_W+1)'(TIMER_NUM));

    // ------------------------------------------------------------------------
    // Round-robin arbiter: search starts one past the last grant and wraps.
    // Only registered pending bits take part, so an expiry is never granted
    // in the cycle it arrives.
    // ------------------------------------------------------------------------
    // NOTE: every variable written in an always_comb gets a default before any
    // conditional logic; otherwise a path that skips the assignment infers a latch.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int off = 1; off <= TIMER_NUM; off++) begin
            if (!w_gnt_vld && r_pending[wrap_add(r_ptr, off)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = wrap_add(r_ptr, off);
            end
        end
    end

    assign w_gnt_oh = w_gnt_vld ? (TIMER_NUM'(1) << w_gnt_idx) : '0;

    // A period write to the channel being granted goes straight through to the
    // reload, so software never races the reload with a stale value.
    assign w_wr_hit     = w_gnt_vld && w_cfg_vld && (cfg_idx == w_gnt_idx);
    assign w_reload_val = w_wr_hit ? cfg_wdata : r_period[w_gnt_idx];

    // ------------------------------------------------------------------------
    // Pending / overflow next state
    //   The grant clears a pending bit, but a new expiry on the same edge sets
    //   it again. That case is a fresh event and is not an overflow. An expiry
    //   on a pending channel that is not granted is merged and flagged. A new
    //   overflow wins over ovf_clr.
    // ------------------------------------------------------------------------
    assign w_pend_nxt = (r_pending & ~w_gnt_oh) | time_out;
    assign w_ovf_set  = time_out & r_pending & ~w_gnt_oh;
    assign w_ovf_nxt  = w_ovf_set | (ovf_clr ? '0 : r_overflow);

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_overflow <= '0;
            r_ptr      <= IDX_W'(TIMER_NUM - 1);
        end else begin
            r_pending  <= w_pend_nxt;
            r_overflow <= w_ovf_nxt;
            if (w_gnt_vld) begin
                r_ptr <= w_gnt_idx;
            end
        end
    end

    // NOTE: the period and load arrays are reset on purpose. They are small
    // register files with defined reset contents, not RAMs, so a reset does
    // not prevent them from being mapped efficiently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TIMER_NUM; i++) begin
                r_period[i] <= LOAD_W'(DEFAULT_PERIOD);
                r_load[i]   <= '0;
            end
        end else begin
            if (w_cfg_vld) begin
                r_period[cfg_idx] <= cfg_wdata;
            end
            for (int i = 0; i < TIMER_NUM; i++) begin
                if (w_gnt_oh[i]) begin
                    r_load[i] <= w_reload_val;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < TIMER_NUM; g++) begin : g_pack
        assign load_value[g*LOAD_W +: LOAD_W] = r_load[g];
    end

    assign busy     = |r_pending;
    assign overflow = r_overflow;

`ifdef TIMEOUT_CNT_EN
    // ------------------------------------------------------------------------
    // Per-channel event counters, saturating at 255
    // ------------------------------------------------------------------------
    logic [7:0] r_cnt [TIMER_NUM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TIMER_NUM; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TIMER_NUM; i++) begin
                if (time_out[i] && (r_cnt[i] != 8'hFF)) begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign cnt_rdata = ({1'b0, cnt_idx} < (IDX_W+1)'(TIMER_NUM)) ? r_cnt[cnt_idx] : 8'd0;
`endif

endmodule

// File: tb/tb_timer_reload_ctrl.sv
// ============================================================================
// tb_timer_reload_ctrl
//
// Directed testbench for timer_reload_ctrl with default parameters
// (5 channels, 10-bit loads, default period 9). Each scenario task drives its
// stimulus and compares the outputs against hand-computed values. Inputs
// change 1 time unit after a rising edge. Outputs are sampled at the same
// point, after the edge has settled. When TIMEOUT_CNT_EN is defined, the
// event-counter read port is also exercised.
// ============================================================================
module tb_timer_reload_ctrl;

    localparam int N = 5;
    localparam int W = 10;
    localparam int IW = 3;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   time_out;
    logic [N*W-1:0] load_value;
    logic           cfg_we;
    logic [IW-1:0]  cfg_idx;
    logic [W-1:0]   cfg_wdata;
    logic           busy;
    logic [N-1:0]   overflow;
    logic           ovf_clr;
`ifdef TIMEOUT_CNT_EN
    logic [IW-1:0]  cnt_idx;
    logic [7:0]     cnt_rdata;
`endif

    int n_cmp;
    int n_bad;

    timer_reload_ctrl #(
        .TIMER_NUM      (N),
        .LOAD_W         (W),
        .DEFAULT_PERIOD (9)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .time_out   (time_out),
        .load_value (load_value),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_wdata  (cfg_wdata),
        .busy       (busy),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
`ifdef TIMEOUT_CNT_EN
       ,.cnt_idx    (cnt_idx),
        .cnt_rdata  (cnt_rdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog. The scenarios are bounded loops, so this fires only if
    // something is badly wrong.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        time_out  = '0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_wdata = '0;
        ovf_clr   = 1'b0;
`ifdef TIMEOUT_CNT_EN
        cnt_idx   = '0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Compare all outputs against one expected set; name tags the step.
    task automatic cmp_all(input string name, input logic [N*W-1:0] exp_lv,
                           input logic exp_busy, input logic [N-1:0] exp_ovf);
        n_cmp++;
        if (load_value !== exp_lv) begin
            n_bad++;
            $display("FAIL %s load_value: got %h expected %h", name, load_value, exp_lv);
        end
        n_cmp++;
        if (busy !== exp_busy) begin
            n_bad++;
            $display("FAIL %s busy: got %b expected %b", name, busy, exp_busy);
        end
        n_cmp++;
        if (overflow !== exp_ovf) begin
            n_bad++;
            $display("FAIL %s overflow: got %b expected %b", name, overflow, exp_ovf);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        cmp_all("reset_async", '0, 1'b0, '0);
        tick();
        rst_n = 1'b1;
        tick();
        cmp_all("reset_release_idle", '0, 1'b0, '0);
    endtask

    // Single channel: busy for exactly one cycle, slice 2 becomes 9.
    task automatic test_single();
        logic [N*W-1:0] exp_lv;
        exp_lv = '0;
        time_out = 5'b00100;
        tick();
        time_out = '0;
        cmp_all("single_pending", exp_lv, 1'b1, '0);
        tick();
        exp_lv[2*W +: W] = 10'd9;
        cmp_all("single_loaded", exp_lv, 1'b0, '0);
        tick();
        cmp_all("single_hold", exp_lv, 1'b0, '0);
    endtask

    // All channels at once: one grant per cycle in order 0..4; slice 1 uses
    // the written period 14.
    task automatic test_round_robin();
        logic [N*W-1:0] exp_lv;
        do_reset();
        cfg_we    = 1'b1;
        cfg_idx   = 3'd1;
        cfg_wdata = 10'd14;
        tick();
        idle_inputs();
        time_out = 5'b11111;
        tick();
        time_out = '0;
        exp_lv = '0;
        cmp_all("rr_all_pending", exp_lv, 1'b1, '0);
        for (int j = 0; j < N; j++) begin
            tick();
            exp_lv[j*W +: W] = (j == 1) ? 10'd14 : 10'd9;
            cmp_all($sformatf("rr_grant_%0d", j), exp_lv, (j != N-1), '0);
        end
    endtask

    // Merged event on a waiting channel sets overflow. ovf_clr clears it,
    // but a simultaneous new overflow takes priority over the clear.
    task automatic test_overflow();
        logic [N*W-1:0] exp_lv;
        do_reset();
        exp_lv = '0;
        time_out = 5'b01111;
        tick();
        time_out = 5'b01000;         // channel 0 is granted this cycle; 3 still waits
        tick();
        time_out = '0;
        exp_lv[0*W +: W] = 10'd9;
        cmp_all("ovf_set", exp_lv, 1'b1, 5'b01000);
        tick();
        tick();
        tick();
        exp_lv[1*W +: W] = 10'd9;
        exp_lv[2*W +: W] = 10'd9;
        exp_lv[3*W +: W] = 10'd9;
        cmp_all("ovf_sticky_drained", exp_lv, 1'b0, 5'b01000);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        cmp_all("ovf_cleared", exp_lv, 1'b0, 5'b00000);
        // Last grant was 3: channels 0 and 1 pending, 0 is granted first.
        time_out = 5'b00011;
        tick();
        time_out = 5'b00010;         // channel 1 is waiting: overflow
        ovf_clr  = 1'b1;             // clear in the same cycle loses
        tick();
        idle_inputs();
        cmp_all("ovf_beats_clr", exp_lv, 1'b1, 5'b00010);
        tick();
        cmp_all("ovf_prio_drained", exp_lv, 1'b0, 5'b00010);
    endtask

    // Expiry arriving in the grant cycle is a new event, not an overflow.
    task automatic test_same_cycle();
        logic [N*W-1:0] exp_lv;
        do_reset();
        exp_lv = '0;
        time_out = 5'b00001;
        tick();
        tick();                      // edge grants 0 and samples a new time_out[0]
        time_out = '0;
        exp_lv[0*W +: W] = 10'd9;
        cmp_all("same_cycle_repend", exp_lv, 1'b1, '0);
        tick();                      // second grant of channel 0
        cmp_all("same_cycle_regrant", exp_lv, 1'b0, '0);
    endtask

    // Write-through in the grant cycle, an out-of-range write ignored,
    // a zero period passed through, and reset with channels pending.
    task automatic test_write_through_and_reset();
        logic [N*W-1:0] exp_lv;
        do_reset();
        exp_lv = '0;
        time_out = 5'b10000;
        tick();
        time_out  = '0;
        cfg_we    = 1'b1;
        cfg_idx   = 3'd4;
        cfg_wdata = 10'd3;
        tick();                      // grant 4 with simultaneous write
        idle_inputs();
        exp_lv[4*W +: W] = 10'd3;
        cmp_all("write_through", exp_lv, 1'b0, '0);

        // Out-of-range index: nothing may change.
        cfg_we    = 1'b1;
        cfg_idx   = 3'd5;
        cfg_wdata = 10'd77;
        tick();
        cfg_idx   = 3'd7;
        tick();
        idle_inputs();
        time_out = 5'b11111;
        tick();
        time_out = '0;
        for (int j = 0; j < N; j++) tick();
        exp_lv[0*W +: W] = 10'd9;
        exp_lv[1*W +: W] = 10'd9;
        exp_lv[2*W +: W] = 10'd9;
        exp_lv[3*W +: W] = 10'd9;
        cmp_all("ignored_write", exp_lv, 1'b0, '0);

        // Period 0 reaches the slice unchanged (9 -> 0).
        cfg_we    = 1'b1;
        cfg_idx   = 3'd2;
        cfg_wdata = 10'd0;
        tick();
        idle_inputs();
        time_out = 5'b00100;
        tick();
        time_out = '0;
        tick();
        exp_lv[2*W +: W] = 10'd0;
        cmp_all("zero_period", exp_lv, 1'b0, '0);

        // Three channels pending, then asynchronous reset mid-cycle.
        time_out = 5'b00111;
        tick();
        time_out = '0;
        cmp_all("pre_reset_pending", exp_lv, 1'b1, '0);
        #2;
        rst_n = 1'b0;
        #1;
        cmp_all("reset_while_pending", '0, 1'b0, '0);
        tick();
        rst_n = 1'b1;
        tick();
        cmp_all("post_reset_1", '0, 1'b0, '0);
        tick();
        tick();
        cmp_all("post_reset_3", '0, 1'b0, '0);
    endtask

`ifdef TIMEOUT_CNT_EN
    // 300 sampled events on channel 1 saturate its counter at 255.
    task automatic test_counter();
        do_reset();
        cnt_idx  = 3'd1;
        time_out = 5'b00010;
        for (int k = 0; k < 100; k++) tick();
        n_cmp++;
        if (cnt_rdata !== 8'd100) begin
            n_bad++;
            $display("FAIL cnt_100: got %0d expected 100", cnt_rdata);
        end
        for (int k = 0; k < 200; k++) tick();
        time_out = '0;
        tick();
        n_cmp++;
        if (cnt_rdata !== 8'd255) begin
            n_bad++;
            $display("FAIL cnt_saturate: got %0d expected 255", cnt_rdata);
        end
        cnt_idx = 3'd0;
        #1;
        n_cmp++;
        if (cnt_rdata !== 8'd0) begin
            n_bad++;
            $display("FAIL cnt_other_channel: got %0d expected 0", cnt_rdata);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_same_cycle();
        test_write_through_and_reset();
`ifdef TIMEOUT_CNT_EN
        test_counter();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
